// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract engine.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a requesting unit (master) and the adder (slave).
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, op_sub, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, op_sub, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );

endinterface

// File: rtl/nibble_serial_adder_rca.sv
// Plain 4-bit ripple-carry adder; the only adder hardware in the engine.
module RCA_4b
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic                c_out
);

  logic [NIBBLE_W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single RCA_4b,
// LSB first, with a start/busy/done handshake.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             ovf_r;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sh_r;
  logic             carry_r;
  logic             a_msb_r;
  logic             b_msb_r;

  logic [WIDTH-1:0]    b_eff;
  logic                accept;
  logic                last_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic                c_nib;
  logic [WIDTH-1:0]    sh_next;

  // Subtraction is a + ~b + 1, so the inversion happens once at accept time.
  assign b_eff    = bus.op_sub ? ~bus.b : bus.b;
  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign last_nib = (state == RUN) && (cnt == CNT_LAST);

  RCA_4b u_rca (
    .a     (a_r[NIBBLE_W-1:0]),
    .b     (b_r[NIBBLE_W-1:0]),
    .c_in  (carry_r),
    .s     (s_nib),
    .c_out (c_nib)
  );

  // New nibble enters at the top; after NIB shifts the register holds the full result.
  assign sh_next = (WIDTH'(s_nib) << (WIDTH - NIBBLE_W)) | (sh_r >> NIBBLE_W);

  // Operand/shift datapath: loaded on accept, advanced one nibble per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r     <= bus.a;
      b_r     <= b_eff;
      carry_r <= bus.op_sub ? 1'b1 : bus.c_in;
      a_msb_r <= bus.a[WIDTH-1];
      b_msb_r <= b_eff[WIDTH-1];
    end else if (state == RUN) begin
      a_r     <= a_r >> NIBBLE_W;
      b_r     <= b_r >> NIBBLE_W;
      sh_r    <= sh_next;
      carry_r <= c_nib;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= RUN;
            cnt    <= '0;
            busy_r <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (last_nib) begin
            state   <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            sum_r   <= sh_next;
            c_out_r <= c_nib;
            ovf_r   <= ovf_of(a_msb_r, b_msb_r, s_nib[NIBBLE_W-1]);
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.c_out = c_out_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH = 16).
module tb_nibble_serial_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t last_exp;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0]   t;
    logic [W-1:0] be;
    exp_t         r;
    be    = sub ? ~b : b;
    t     = {1'b0, a} + {1'b0, be} + (W+1)'(sub ? 1'b1 : cin);
    r.sum = t[W-1:0];
    r.c   = t[W];
    r.v   = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    bus.a      = a;
    bus.b      = b;
    bus.c_in   = cin;
    bus.op_sub = sub;
    bus.start  = 1'b1;
  endtask

  // Called at the negedge where start was raised; returns edges from accept to done.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.c_in = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy  !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done  !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.sum   !== '0)   begin bad++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
    total++; if (bus.c_out !== 1'b0) begin bad++; $display("FAIL reset_c_out: got %b want 0", bus.c_out); end
    total++; if (bus.ovf   !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    rst = 1'b0;
  endtask

  task automatic test_add;
    logic [W-1:0] ta [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    logic [W-1:0] tb [4] = '{16'h0FFF, 16'h0001, 16'h0000, 16'h0001};
    logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_t         te [4] = '{{16'h2233, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0},
                             {16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1}};
    int lat, bn;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i], tc[i], 1'b0);
      sb.push_back(te[i]);
      wait_done(lat, bn);
      total++; if (lat !== 4) begin bad++; $display("FAIL add_latency[%0d]: got %0d want 4", i, lat); end
      total++; if (bn !== 4)  begin bad++; $display("FAIL add_busy_cycles[%0d]: got %0d want 4", i, bn); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (lat >= 0) begin
          last_exp = e;
          total++; if (bus.sum !== e.sum) begin bad++; $display("FAIL add_sum[%0d]: got %h want %h", i, bus.sum, e.sum); end
          total++; if (bus.c_out !== e.c) begin bad++; $display("FAIL add_c_out[%0d]: got %b want %b", i, bus.c_out, e.c); end
          total++; if (bus.ovf !== e.v)   begin bad++; $display("FAIL add_ovf[%0d]: got %b want %b", i, bus.ovf, e.v); end
        end
      end
      if (i == 0) begin
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", bus.done); end
      end
    end
  endtask

  task automatic test_sub;
    logic [W-1:0] ta [3] = '{16'h0005, 16'h0005, 16'h8000};
    logic [W-1:0] tb [3] = '{16'h0007, 16'h0007, 16'h0001};
    logic         tc [3] = '{1'b0, 1'b1, 1'b0};
    exp_t         te [3] = '{{16'hFFFE, 1'b0, 1'b0}, {16'hFFFE, 1'b0, 1'b0},
                             {16'h7FFF, 1'b1, 1'b1}};
    int lat, bn;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i], tc[i], 1'b1);
      sb.push_back(te[i]);
      wait_done(lat, bn);
      total++; if (lat !== 4) begin bad++; $display("FAIL sub_latency[%0d]: got %0d want 4", i, lat); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (lat >= 0) begin
          last_exp = e;
          total++; if (bus.sum !== e.sum) begin bad++; $display("FAIL sub_sum[%0d]: got %h want %h", i, bus.sum, e.sum); end
          total++; if (bus.c_out !== e.c) begin bad++; $display("FAIL sub_c_out[%0d]: got %b want %b", i, bus.c_out, e.c); end
          total++; if (bus.ovf !== e.v)   begin bad++; $display("FAIL sub_ovf[%0d]: got %b want %b", i, bus.ovf, e.v); end
        end
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    int lat, bn;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      @(negedge clk);
      drive(ra, rb, rc, rs);
      sb.push_back(model(ra, rb, rc, rs));
      wait_done(lat, bn);
      total++; if (lat !== 4) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want 4", i, lat); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (lat >= 0) begin
          last_exp = e;
          total++;
          if ({bus.sum, bus.c_out, bus.ovf} !== {e.sum, e.c, e.v}) begin
            bad++;
            $display("FAIL rnd_result[%0d] a=%h b=%h cin=%b sub=%b: got %h/%b/%b want %h/%b/%b",
                     i, ra, rb, rc, rs, bus.sum, bus.c_out, bus.ovf, e.sum, e.c, e.v);
          end
        end
      end
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    logic got;
    @(negedge clk);
    drive(16'h00FF, 16'h0101, 1'b1, 1'b0);
    sb.push_back(model(16'h00FF, 16'h0101, 1'b1, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.sum !== last_exp.sum) begin bad++; $display("FAIL sum_on_accept: got %h want %h", bus.sum, last_exp.sum); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ign_busy: got %b want 1", bus.busy); end
    @(posedge clk);
    @(negedge clk);
    drive(16'hAAAA, 16'h5555, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin got = 1'b1; break; end
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL ign_done: got no done want done"); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        last_exp = e;
        total++; if (bus.sum !== e.sum) begin bad++; $display("FAIL ign_sum: got %h want %h", bus.sum, e.sum); end
      end
    end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_not_queued: got busy %b want 0", bus.busy); end
  endtask

  task automatic test_hold_idle;
    int errs;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.sum !== last_exp.sum || bus.busy !== 1'b0 || bus.done !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL hold_idle: got %0d bad cycles (sum %h) want 0 (sum %h)", errs, bus.sum, last_exp.sum); end
  endtask

  task automatic test_back_to_back;
    int d1, d2;
    exp_t e;
    d1 = -1;
    d2 = -1;
    @(negedge clk);
    drive(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    sb.push_back(model(16'h1234, 16'h0FFF, 1'b0, 1'b0));
    sb.push_back(model(16'h8000, 16'h0001, 1'b0, 1'b1));
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) drive(16'h8000, 16'h0001, 1'b0, 1'b1);
      if (bus.done === 1'b1) begin
        if (d1 < 0) d1 = i; else d2 = i;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          last_exp = e;
          total++;
          if ({bus.sum, bus.c_out, bus.ovf} !== {e.sum, e.c, e.v}) begin
            bad++;
            $display("FAIL b2b_result@%0d: got %h/%b/%b want %h/%b/%b", i, bus.sum, bus.c_out, bus.ovf, e.sum, e.c, e.v);
          end
        end
        if (d2 >= 0) begin
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    total++; if (d1 !== 4) begin bad++; $display("FAIL b2b_first_done: got %0d want 4", d1); end
    total++; if (d2 - d1 !== 5) begin bad++; $display("FAIL b2b_spacing: got %0d want 5", d2 - d1); end
  endtask

  task automatic test_reset_mid_run;
    int pulses, lat, bn;
    exp_t e;
    @(negedge clk);
    drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
    total++; if ({bus.sum, bus.c_out, bus.ovf} !== '0) begin bad++; $display("FAIL rstmid_result: got %h/%b/%b want 0000/0/0", bus.sum, bus.c_out, bus.ovf); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", pulses); end
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    sb.push_back(model(16'h7FFF, 16'h0001, 1'b0, 1'b0));
    wait_done(lat, bn);
    total++; if (lat !== 4) begin bad++; $display("FAIL rstmid_after_latency: got %0d want 4", lat); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (lat >= 0) begin
        total++;
        if ({bus.sum, bus.c_out, bus.ovf} !== {e.sum, e.c, e.v}) begin
          bad++;
          $display("FAIL rstmid_after_result: got %h/%b/%b want %h/%b/%b", bus.sum, bus.c_out, bus.ovf, e.sum, e.c, e.v);
        end
      end
    end
  endtask

  initial begin
    last_exp = '0;
    test_reset();
    test_add();
    test_sub();
    test_random();
    test_ignore_start();
    test_hold_idle();
    test_back_to_back();
    test_reset_mid_run();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
